// File: rtl/run_pkg.sv
// run_pkg: shared encodings for the run detector self-test
package run_pkg;
  localparam int LEN_DEFAULT = 16;
  localparam logic [3:0] DET_A = 4'd0;
  localparam logic [3:0] DET_B = 4'd1;
  localparam logic [3:0] DET_C = 4'd2;
  localparam logic [3:0] DET_D = 4'd3;
  localparam logic [3:0] DET_E = 4'd4;
  localparam logic [3:0] DET_F = 4'd5;
  localparam logic [3:0] DET_G = 4'd6;
  localparam logic [3:0] DET_H = 4'd7;
  localparam logic [3:0] DET_I = 4'd8;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SHIFT, ST_DRAIN, ST_DONE} ctl_state_t;
endpackage

// File: rtl/run_detector.sv
// run_detector: Moore detector flagging four or more equal consecutive bits
module run_detector
  import run_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic w,
  output logic z
);
  logic [3:0] s_q, s_d;
  // zero runs climb A..E, one runs climb F..I, a bit change restarts the opposite chain
  always_comb begin
    s_d = w ? (s_q <= DET_E ? DET_F : s_q == DET_I ? DET_I : s_q + 4'd1)
            : (s_q <= DET_D ? s_q + 4'd1 : s_q == DET_E ? DET_E : DET_B);
  end
  // state register, clear returns to A
  always_ff @(posedge clock) begin
    s_q <= clear ? DET_A : s_d;
  end
  assign z = (s_q == DET_E) || (s_q == DET_I);
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: plays a stored pattern into run_detector and counts run hits
module run_sequencer
  import run_pkg::*;
#(
  parameter int LEN = LEN_DEFAULT,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [LEN-1:0] pattern,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  hits,
  output logic           w_mon,
  output logic           z_mon
);
  localparam int IW = $clog2(LEN);
  ctl_state_t state_q, state_d;
  logic [LEN-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] hits_q, hits_d;
  logic busy_q, busy_d, done_q, done_d, w_q, w_d;
  logic z;
  run_detector u_det (
    .clock(clock),
    .clear(reset || state_q == ST_CLEAR),
    .w    (w_q),
    .z    (z)
  );
  // next state, datapath and registered outputs derived from the next state
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    hits_d  = hits_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CLEAR;
        sr_d    = pattern;
        idx_d   = '0;
        hits_d  = '0;
      end
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: begin
        sr_d    = {sr_q[LEN-2:0], 1'b0};
        idx_d   = idx_q + IW'(1);
        state_d = idx_q == IW'(LEN - 1) ? ST_DRAIN : ST_SHIFT;
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if ((state_q == ST_SHIFT && idx_q != '0) || state_q == ST_DRAIN) hits_d = hits_q + CW'(z);
    if (abort && state_q inside {ST_CLEAR, ST_SHIFT, ST_DRAIN}) state_d = ST_IDLE;
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_DONE;
    w_d    = state_d == ST_SHIFT ? sr_d[LEN-1] : 1'b0;
  end
  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      hits_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      hits_q  <= hits_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      w_q     <= w_d;
    end
  end
  assign busy  = busy_q;
  assign done  = done_q;
  assign hits  = hits_q;
  assign w_mon = w_q;
  assign z_mon = z;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed vectors and corner sequences for run_sequencer
module tb_run_sequencer;
  localparam int LEN = 16;
  localparam int CW = $clog2(LEN + 1);
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [LEN-1:0] pattern = '0;
  logic busy, done, w_mon, z_mon;
  logic [CW-1:0] hits;
  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic [15:0] pat;
    int          hits;
    logic        z19;
  } vec_t;
  vec_t vecs[5];

  always #5 clock = ~clock;

  run_sequencer #(.LEN(LEN)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .pattern(pattern),
    .busy   (busy),
    .done   (done),
    .hits   (hits),
    .w_mon  (w_mon),
    .z_mon  (z_mon)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic launch(input logic [LEN-1:0] p, input logic ab);
    pattern = p;
    start = 1'b1;
    abort = ab;
    tick();
    start = 1'b0;
    abort = 1'b0;
    cyc = 1;
  endtask

  task automatic run_vec(input vec_t v, input logic ab);
    int dcnt = 0, dcyc = 0;
    logic b1 = 0, b19 = 0, b20 = 1, w2 = 0, w17 = 0, w18 = 1, z19 = 0;
    logic [CW-1:0] h19 = '0;
    string tag;
    tag = $sformatf("pat%h%s", v.pat, ab ? "_ab" : "");
    launch(v.pat, ab);
    while (cyc < 24) begin
      if (done) begin
        dcnt++;
        dcyc = cyc;
      end
      case (cyc)
        1: b1 = busy;
        2: w2 = w_mon;
        17: w17 = w_mon;
        18: w18 = w_mon;
        19: begin b19 = busy; z19 = z_mon; h19 = hits; end
        20: b20 = busy;
        default: ;
      endcase
      tick();
    end
    chk({tag, " busy_c1"}, 32'(b1), 32'd1);
    chk({tag, " done_cnt"}, 32'(dcnt), 32'd1);
    chk({tag, " done_cyc"}, 32'(dcyc), 32'd19);
    chk({tag, " w_first"}, 32'(w2), 32'(v.pat[15]));
    chk({tag, " w_last"}, 32'(w17), 32'(v.pat[0]));
    chk({tag, " w_drain"}, 32'(w18), 32'd0);
    chk({tag, " busy_c19"}, 32'(b19), 32'd1);
    chk({tag, " busy_c20"}, 32'(b20), 32'd0);
    chk({tag, " hits_done"}, 32'(h19), 32'(v.hits));
    chk({tag, " z_c19"}, 32'(z19), 32'(v.z19));
    chk({tag, " hits_hold"}, 32'(hits), 32'(v.hits));
  endtask

  initial begin
    int dcnt, d1, d2;
    logic b9, w9, b20, b21;
    logic [CW-1:0] h19;
    repeat (3) tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hits", 32'(hits), 32'd0);
    chk("rst w_mon", 32'(w_mon), 32'd0);
    chk("rst z_mon", 32'(z_mon), 32'd0);
    reset = 1'b0;
    tick();
    vecs[0] = '{16'h0000, 13, 1'b1};
    vecs[1] = '{16'hFFFF, 13, 1'b0};
    vecs[2] = '{16'hAAAA, 0, 1'b0};
    vecs[3] = '{16'hF0F0, 4, 1'b1};
    vecs[4] = '{16'h00FF, 10, 1'b0};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);
    run_vec(vecs[3], 1'b1);

    dcnt = 0; d1 = 0; d2 = 0; b20 = 1; b21 = 0; h19 = '0;
    launch(16'h0000, 1'b0);
    while (cyc < 45) begin
      if (done) begin
        dcnt++;
        if (d1 == 0) d1 = cyc; else d2 = cyc;
      end
      case (cyc)
        5: begin start = 1'b1; pattern = 16'hAAAA; end
        6: start = 1'b0;
        19: begin start = 1'b1; h19 = hits; end
        20: begin b20 = busy; pattern = 16'hF0F0; end
        21: begin start = 1'b0; b21 = busy; end
        default: ;
      endcase
      tick();
    end
    chk("restart done_cnt", 32'(dcnt), 32'd2);
    chk("restart first_done", 32'(d1), 32'd19);
    chk("restart second_done", 32'(d2), 32'd39);
    chk("restart hits1", 32'(h19), 32'd13);
    chk("restart busy_c20", 32'(b20), 32'd0);
    chk("restart busy_c21", 32'(b21), 32'd1);
    chk("restart hits2", 32'(hits), 32'd4);

    dcnt = 0; b9 = 1; w9 = 1;
    launch(16'h0000, 1'b0);
    while (cyc < 30) begin
      if (done) dcnt++;
      case (cyc)
        8: abort = 1'b1;
        9: begin abort = 1'b0; b9 = busy; w9 = w_mon; end
        default: ;
      endcase
      tick();
    end
    chk("abort done_cnt", 32'(dcnt), 32'd0);
    chk("abort busy_c9", 32'(b9), 32'd0);
    chk("abort w_c9", 32'(w9), 32'd0);
    chk("abort hits", 32'(hits), 32'd3);

    launch(16'h0000, 1'b0);
    while (cyc < 10) tick();
    chk("prereset z_c10", 32'(z_mon), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hits", 32'(hits), 32'd0);
    chk("midrst w_mon", 32'(w_mon), 32'd0);
    chk("midrst z_mon", 32'(z_mon), 32'd0);
    tick();
    run_vec(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Self-test controller for the consecutive-run detector. It loads a stored bit pattern and applies it one bit per clock to an internal run-detector instance. It counts the cycles in which the detector flags a run of four equal bits, then reports the count with a one-cycle `done` pulse. It sits beside the board-level detector wiring and replaces the hand-clocked switch/key stimulus for regression and on-board demos.

## Interface
- `LEN`, 16: pattern length in bits; legal range 4..32.
- `CW`, `$clog2(LEN+1)`: width of the hit counter.

- `clock` in 1: single clock domain, rising edge.
- `reset` in 1: synchronous, active-high; returns all state to reset values.
- `start` in 1: a request sampled high in IDLE launches a run; ignored in all other states.
- `abort` in 1: when high in CLEAR, SHIFT or DRAIN, the block returns to IDLE next cycle and `done` does not pulse.
- `pattern` in LEN: bit pattern, latched on the accepting `start` edge, shifted MSB first.
- `busy` out 1: high in CLEAR, SHIFT, DRAIN and DONE. Reset value 0.
- `done` out 1: one-cycle pulse in DONE. Reset value 0.
- `hits` out CW: number of z=1 samples in the last completed run. Reset value 0.
- `w_mon` out 1: bit currently driven into the detector. Reset value 0.
- `z_mon` out 1: detector z output. Reset value 0.

## Operation
- Controller FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- **IDLE**
  - `busy`=0.
  - On `start`=1: latch `pattern` into the shift register, set bit index to 0, set `hits` to 0, go to CLEAR.
- **CLEAR** (1 cycle)
  - Drives the detector clear, which forces it to state A.
  - `w_mon`=0.
  - Next state is SHIFT.
- **SHIFT** (LEN cycles)
  - `w_mon` = shift-register MSB.
  - The shift register shifts left each cycle and the index increments.
  - After the cycle with index LEN-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - `w_mon`=0.
  - Samples z for the final bit.
  - Next state is DONE.
- **DONE** (1 cycle)
  - `done`=1.
  - Next state is IDLE.
- Hit counting:
  - z is sampled in every SHIFT cycle except the first, and in DRAIN.
  - When z=1, `hits` increments by 1.
  - Result: `hits` = number of positions k in 3..LEN-1 where bits k-3..k are all equal.
  - Maximum count is LEN-3, so the counter never wraps.
- `hits` holds its value through IDLE until the next accepted `start`.
- Detector (Moore, nine states A..I):
  - A, B, C, D count 0..3 consecutive zeros; E means four or more zeros.
  - F, G, H count 1..3 consecutive ones; I means four or more ones.
  - Transitions on w=0:
    - A→B→C→D→E, E→E.
    - F, G, H, I → B.
  - Transitions on w=1:
    - A, B, C, D, E → F.
    - F→G→H→I, I→I.
  - z = (state==E) or (state==I).
  - The detector clear is the logical OR of `reset` and CLEAR.
- Simultaneous events:
  - `abort` overrides the normal next state.
  - `reset` overrides everything.
  - `start` together with `abort` in IDLE: start wins, because abort is don't-care in IDLE.
- `reset` mid-run: next cycle is IDLE with every output at its reset value and the detector in A.
- `abort` mid-run: `hits` keeps its partial count and `done` stays 0.

## Timing
- Edge 0 is the edge that samples `start`=1.
- CLEAR occupies cycle 1.
- SHIFT occupies cycles 2..LEN+1.
- DRAIN occupies cycle LEN+2.
- DONE occupies cycle LEN+3: `done`=1 and `hits` is final.
- `busy` falls at cycle LEN+4; a new `start` is accepted from cycle LEN+4.
- Total latency is LEN+3 cycles, which is 19 for LEN=16.
- `z_mon` follows the detector state register with no extra latency; z for the bit applied in cycle c is visible in cycle c+1.
- All outputs are registered except `z_mon`, which is decoded from the detector state register.

## Structure
- Package `run_pkg` holds:
  - detector state constants A..I, encoded 4'b0000..4'b1000;
  - controller state encodings IDLE..DONE;
  - the default LEN.
- Sub-module `run_detector`, ports (`clock`, `clear`, `w`, `z`): a four-bit state register plus next-state logic. It is instantiated once.
- Controller FSM, shift register, index counter and hit counter live in `run_sequencer`.

## Test plan
- `pattern`=16'h0000, start pulse → `hits`=13, `done` high exactly at cycle 19, `busy` low at cycle 20.
- `pattern`=16'hFFFF → `hits`=13; `pattern`=16'hAAAA → `hits`=0.
- `pattern`=16'hF0F0 → `hits`=4; `pattern`=16'h00FF → `hits`=10, and `z_mon` low in DRAIN+1 after the detector clear.
- `start` pulsed again at cycles 5 and 19 of a run → ignored, one `done` only; `start` at cycle 20 → new run accepted.
- `abort` at cycle 8 with `pattern`=16'h0000 → IDLE at cycle 9, `done` never pulses, `hits`=3.
- `reset` at cycle 10 → cycle 11: `busy`=0, `done`=0, `hits`=0, `w_mon`=0, `z_mon`=0; the next run with 16'h0000 gives `hits`=13.
